// File: rtl/single_port_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : single_port_ram_pkg
// Purpose  : Shared defaults and word type for the single-port RAM.
// Revision : 1.0 - initial release
// ============================================================================
package single_port_ram_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 6;
  localparam int DEFAULT_DEPTH      = 2 ** DEFAULT_ADDR_WIDTH;

  // One storage word at the default data width.
  typedef logic [DEFAULT_DATA_WIDTH-1:0] word_t;

endpackage : single_port_ram_pkg
`default_nettype wire

// File: rtl/single_port_ram.sv
`default_nettype none
// ============================================================================
// Module   : single_port_ram
// Purpose  : Synchronous single-port RAM with registered output. One shared
//            address; we=1 writes, otherwise the cycle is a read. Write-first
//            on read-during-write. q clears asynchronously on rst, while the
//            array contents are retained across reset.
// Revision : 1.0 - initial release
// ============================================================================
module single_port_ram
  import single_port_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  output logic [DATA_WIDTH-1:0] q
);

  // Storage array. It has no reset term, so that it can map onto RAM
  // resources. Every address value is a valid word because DEPTH is
  // 2**ADDR_WIDTH.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Array write plus output register. The rst branch only touches q, so
  // writes are naturally blocked while rst is high and the contents survive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (we) begin
      mem[addr] <= data;
      q         <= data;
    end else begin
      q <= mem[addr];
    end
  end

endmodule : single_port_ram
`default_nettype wire

// File: tb/tb_single_port_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_single_port_ram
// Purpose  : Self-checking bench for single_port_ram. A driver issues
//            operations and pushes the expected q into a scoreboard queue;
//            a monitor pops and compares one clock later. An associative
//            array serves as the reference memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_single_port_ram;
  import single_port_ram_pkg::*;

  logic        clk;
  logic        rst;
  word_t       data;
  logic [5:0]  addr;
  logic        we;
  word_t       q;

  typedef struct {
    bit         chk;
    bit         is_wr;
    logic [5:0] a;
    word_t      exp;
  } exp_t;

  exp_t  exp_q[$];
  word_t ref_mem [int];   // only written locations exist in the model
  int    checks;
  int    errors;

  single_port_ram dut (
    .clk  (clk),
    .rst  (rst),
    .data (data),
    .addr (addr),
    .we   (we),
    .q    (q)
  );

  // Free-running clock: rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input word_t act, input word_t expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: q=%h expected=%h at %0t", name, act, expv, $time);
    end
  endtask

  // Issue one operation before the next rising edge and queue the expected q.
  task automatic do_op(input bit w, input logic [5:0] a, input word_t d);
    exp_t e;
    @(negedge clk);
    we   = w;
    addr = a;
    data = d;
    e.is_wr = w;
    e.a     = a;
    if (w) begin
      e.chk = 1'b1;
      e.exp = d;
      ref_mem[int'(a)] = d;
    end else if (ref_mem.exists(int'(a))) begin
      e.chk = 1'b1;
      e.exp = ref_mem[int'(a)];
    end else begin
      e.chk = 1'b0;
      e.exp = '0;
    end
    exp_q.push_back(e);
  endtask

  // Wait (bounded) for the monitor to consume every queued expectation.
  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
  endtask

  // Monitor: the RAM answers every cycle, one clock after the operation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (e.chk) begin
          if (e.is_wr) check($sformatf("write_q a=%0d", e.a), q, e.exp);
          else         check($sformatf("read_q a=%0d", e.a), q, e.exp);
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    we     = 1'b0;
    addr   = '0;
    data   = '0;

    // Asynchronous reset before any clock edge.
    #1 rst = 1'b1;
    #1 check("reset_async_q", q, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    #1 check("reset_hold_q", q, 8'h00);

    // Three back-to-back writes.
    do_op(1'b1, 6'd0, 8'h01);
    do_op(1'b1, 6'd1, 8'h02);
    do_op(1'b1, 6'd2, 8'h03);
    // Readback; the data bus carries junk that must be ignored.
    do_op(1'b0, 6'd0, 8'h03);
    do_op(1'b0, 6'd1, 8'h04);
    do_op(1'b0, 6'd2, 8'h03);
    // Overwrite addr 1, read it back immediately, neighbours unchanged.
    do_op(1'b1, 6'd1, 8'hA5);
    do_op(1'b0, 6'd1, 8'h00);
    do_op(1'b0, 6'd0, 8'h00);
    do_op(1'b0, 6'd2, 8'h00);
    drain();

    // Mid-cycle reset between reads; a write attempted under reset is dropped.
    #2 rst = 1'b1;
    #1 check("reset_mid_q", q, 8'h00);
    we = 1'b1; addr = 6'd2; data = 8'hFF;
    @(negedge clk);
    check("reset_held_q", q, 8'h00);
    rst = 1'b0;
    we  = 1'b0;
    do_op(1'b0, 6'd2, 8'h00);   // contents retained, blocked write had no effect
    do_op(1'b0, 6'd1, 8'h00);
    drain();

    // Full sweep, including the top address 0x3F.
    for (int i = 0; i < 64; i++) do_op(1'b1, 6'(i), 8'(i) ^ 8'h5A);
    for (int i = 0; i < 64; i++) do_op(1'b0, 6'(i), 8'($urandom));

    // Randomised mixed traffic against the reference model.
    for (int i = 0; i < 300; i++)
      do_op(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 8'($urandom));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_single_port_ram
`default_nettype wire
